// File: rtl/chunk_assembler.sv
`default_nettype none
// ============================================================================
// Module      : chunk_assembler
// Description : Packs a 24-bit RGB AXI4-Stream into pixel chunks and delivers
//               current/previous chunk pairs through a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module chunk_assembler #(
    parameter int PIXEL_W      = 24,
    parameter int CHUNK_PIXELS = 256
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [PIXEL_W-1:0]              s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tuser,
    output logic [PIXEL_W*CHUNK_PIXELS-1:0] current_chunk,
    output logic [PIXEL_W*CHUNK_PIXELS-1:0] last_chunk,
    output logic                            chunk_valid,
    input  logic                            chunk_ready,
    output logic                            chunk_first,
    output logic [15:0]                     chunk_idx,
    output logic                            sof_err
);

    localparam int               CHUNK_W     = PIXEL_W * CHUNK_PIXELS;
    localparam int               CNT_W       = (CHUNK_PIXELS > 1) ? $clog2(CHUNK_PIXELS) : 1;
    localparam logic [CNT_W-1:0] C_LAST_SLOT = CNT_W'(CHUNK_PIXELS - 1);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;

    logic [1:0]         r_state;
    logic               r_ready_en;
    logic [CNT_W-1:0]   r_pix_cnt;
    logic               r_fill_sof;
    logic [CHUNK_W-1:0] r_fill;

    logic               w_accept;
    logic               w_sof_mid;
    logic               w_final;
    logic               w_handshake;
    logic               w_sof_eff;
    logic [CNT_W-1:0]   w_slot;
    logic [CNT_W-1:0]   w_rslot;
    logic [CHUNK_W-1:0] w_fill_next;
    logic               w_load;
    logic [1:0]         w_state_next;

    assign s_axis_tready = r_ready_en && (r_state != S_STALL);
    assign chunk_valid   = (r_state != S_EMPTY);

    // A tuser away from slot 0 restarts the fill, so it can never complete a chunk.
    assign w_accept    = s_axis_tvalid && s_axis_tready;
    assign w_sof_mid   = w_accept && s_axis_tuser && (r_pix_cnt != '0);
    assign w_final     = w_accept && !w_sof_mid && (r_pix_cnt == C_LAST_SLOT);
    assign w_handshake = chunk_valid && chunk_ready;
    assign w_sof_eff   = r_fill_sof || (w_accept && s_axis_tuser);
    assign w_slot      = w_sof_mid ? '0 : r_pix_cnt;
    assign w_rslot     = C_LAST_SLOT - w_slot;

    // Fill contents including this cycle's pixel; in STALL no pixel is accepted,
    // so this is also the parked chunk.
    always_comb begin
        w_fill_next = r_fill;
        if (w_accept) begin
            w_fill_next[int'(w_rslot)*PIXEL_W +: PIXEL_W] = s_axis_tdata;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_final) begin
                    w_load       = 1'b1;
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_handshake && w_final) begin
                    w_load       = 1'b1;
                    w_state_next = S_HOLD;
                end else if (w_handshake) begin
                    w_state_next = S_EMPTY;
                end else if (w_final) begin
                    w_state_next = S_STALL;
                end
            end
            S_STALL: begin
                if (w_handshake) begin
                    w_load       = 1'b1;
                    w_state_next = S_HOLD;
                end
            end
            default: w_state_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= S_EMPTY;
            r_ready_en    <= 1'b0;
            r_pix_cnt     <= '0;
            r_fill_sof    <= 1'b0;
            r_fill        <= '0;
            current_chunk <= '0;
            last_chunk    <= '0;
            chunk_first   <= 1'b0;
            chunk_idx     <= 16'd0;
            sof_err       <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ready_en <= 1'b1;
            r_fill_sof <= w_load ? 1'b0 : w_sof_eff;
            if (w_accept) begin
                r_fill <= w_fill_next;
                if (w_sof_mid) begin
                    r_pix_cnt <= CNT_W'(1);
                end else if (r_pix_cnt == C_LAST_SLOT) begin
                    r_pix_cnt <= '0;
                end else begin
                    r_pix_cnt <= r_pix_cnt + CNT_W'(1);
                end
            end
            if (w_sof_mid) begin
                sof_err <= 1'b1;
            end
            if (w_load) begin
                current_chunk <= w_fill_next;
                last_chunk    <= w_sof_eff ? '0 : current_chunk;
                chunk_first   <= w_sof_eff;
                chunk_idx     <= w_sof_eff ? 16'd0 : chunk_idx + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chunk_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_chunk_assembler
// Description : Directed and randomized bench for chunk_assembler against a
//               queue-based model of chunk delivery.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chunk_assembler;

    localparam int PW = 24;
    localparam int CP = 256;
    localparam int CW = PW * CP;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [PW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tuser = 1'b0;
    logic [CW-1:0] current_chunk;
    logic [CW-1:0] last_chunk;
    logic          chunk_valid;
    logic          chunk_ready = 1'b0;
    logic          chunk_first;
    logic [15:0]   chunk_idx;
    logic          sof_err;

    always #5 aclk = ~aclk;

    chunk_assembler #(.PIXEL_W(PW), .CHUNK_PIXELS(CP)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tuser  (s_axis_tuser),
        .current_chunk (current_chunk),
        .last_chunk    (last_chunk),
        .chunk_valid   (chunk_valid),
        .chunk_ready   (chunk_ready),
        .chunk_first   (chunk_first),
        .chunk_idx     (chunk_idx),
        .sof_err       (sof_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [CW-1:0] data;
        logic [CW-1:0] last;
        logic          first;
        logic [15:0]   idx;
    } chunk_t;

    // Model: queue of completed chunks awaiting the processor, head = presented.
    chunk_t        q[$];
    logic [PW-1:0] m_fill[CP];
    int            m_cnt;
    bit            m_sof;
    bit            m_sof_err;
    bit            m_ready_en;
    logic [CW-1:0] m_prev;
    logic [15:0]   m_prev_idx;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] px(input logic [CW-1:0] c, input int k);
        return c[(CP-1-k)*PW +: PW];
    endfunction

    task automatic check_chunk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        int k;
        k = 0;
        for (int i = 0; i < CP; i++) begin
            if (px(got, i) !== px(exp, i)) begin
                k = i;
                break;
            end
        end
        check_eq($sformatf("%s.px%0d", tag, k), 64'(px(got, k)), 64'(px(exp, k)));
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < CP; i++) m_fill[i] = '0;
        m_cnt      = 0;
        m_sof      = 1'b0;
        m_sof_err  = 1'b0;
        m_ready_en = 1'b0;
        m_prev     = '0;
        m_prev_idx = 16'd0;
    endtask

    // One clock: drive inputs, compare outputs to the model, advance the model.
    task automatic cycle(input logic vld, input logic [PW-1:0] d, input logic usr,
                         input logic rdy, output logic acc);
        logic   exp_rdy;
        chunk_t c;
        s_axis_tvalid = vld;
        s_axis_tdata  = d;
        s_axis_tuser  = usr;
        chunk_ready   = rdy;
        exp_rdy = m_ready_en && (q.size() < 2);
        check_eq("tready", 64'(s_axis_tready), 64'(exp_rdy));
        check_eq("valid", 64'(chunk_valid), 64'(q.size() > 0));
        check_eq("sof_err", 64'(sof_err), 64'(m_sof_err));
        if (q.size() > 0) begin
            check_chunk("cur", current_chunk, q[0].data);
            check_chunk("last", last_chunk, q[0].last);
            check_eq("first", 64'(chunk_first), 64'(q[0].first));
            check_eq("idx", 64'(chunk_idx), 64'(q[0].idx));
        end
        acc = vld && exp_rdy;
        if (q.size() > 0 && rdy) void'(q.pop_front());
        if (acc) begin
            if (usr && m_cnt != 0) begin
                m_sof_err = 1'b1;
                m_fill[0] = d;
                m_cnt     = 1;
                m_sof     = 1'b1;
            end else begin
                if (usr) m_sof = 1'b1;
                m_fill[m_cnt] = d;
                if (m_cnt == CP - 1) begin
                    for (int k = 0; k < CP; k++) c.data[(CP-1-k)*PW +: PW] = m_fill[k];
                    c.first    = m_sof;
                    c.idx      = m_sof ? 16'd0 : m_prev_idx + 16'd1;
                    c.last     = m_sof ? '0 : m_prev;
                    m_prev     = c.data;
                    m_prev_idx = c.idx;
                    q.push_back(c);
                    m_sof = 1'b0;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
        m_ready_en = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic send_pix(input logic [PW-1:0] d, input logic usr, input logic rdy);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            cycle(1'b1, d, usr, rdy, acc);
            tries++;
        end
        if (!acc) check_eq("send_timeout", 64'(acc), 64'(1));
    endtask

    task automatic idle(input logic rdy);
        logic acc;
        cycle(1'b0, '0, 1'b0, rdy, acc);
    endtask

    // Called at a falling edge; leaves reset released at a falling edge.
    task automatic do_reset();
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        chunk_ready   = 1'b0;
        aresetn       = 1'b0;
        #1;
        check_eq("rst_tready", 64'(s_axis_tready), 64'(0));
        check_eq("rst_valid", 64'(chunk_valid), 64'(0));
        check_chunk("rst_cur", current_chunk, '0);
        check_chunk("rst_last", last_chunk, '0);
        check_eq("rst_first", 64'(chunk_first), 64'(0));
        check_eq("rst_idx", 64'(chunk_idx), 64'(0));
        check_eq("rst_sof_err", 64'(sof_err), 64'(0));
        model_reset();
        @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    initial begin
        logic acc;
        int   guard;
        model_reset();
        @(negedge aclk);
        do_reset();

        // Single chunk: pixel k = k, tuser on pixel 0
        for (int k = 0; k < CP; k++) send_pix(PW'(k), k == 0, 1'b1);
        check_eq("sc_valid", 64'(chunk_valid), 64'(1));
        check_eq("sc_msb", 64'(px(current_chunk, 0)), 64'h000000);
        check_eq("sc_lsb", 64'(current_chunk[PW-1:0]), 64'h0000FF);
        check_chunk("sc_last", last_chunk, '0);
        check_eq("sc_first", 64'(chunk_first), 64'(1));
        check_eq("sc_idx", 64'(chunk_idx), 64'(0));

        // Chaining
        for (int k = 0; k < CP; k++) send_pix(24'hFFFFFF, k == 0, 1'b1);
        for (int k = 0; k < CP; k++) send_pix(24'h8B4500, 1'b0, 1'b1);
        check_eq("ch_cur", 64'(px(current_chunk, 17)), 64'h8B4500);
        check_eq("ch_last", 64'(px(last_chunk, 200)), 64'hFFFFFF);
        check_eq("ch_first", 64'(chunk_first), 64'(0));
        check_eq("ch_idx", 64'(chunk_idx), 64'(1));
        idle(1'b1);

        // Backpressure into STALL, release with a single ready pulse
        for (int k = 0; k < 2*CP; k++) send_pix(24'h100000 + PW'(k), k == 0, 1'b0);
        check_eq("bp_tready", 64'(s_axis_tready), 64'(0));
        check_eq("bp_valid", 64'(chunk_valid), 64'(1));
        check_eq("bp_cur", 64'(px(current_chunk, 0)), 64'h100000);
        idle(1'b1);
        check_eq("bp_cur2", 64'(px(current_chunk, 0)), 64'h100100);
        check_eq("bp_last2", 64'(px(last_chunk, CP-1)), 64'h1000FF);
        check_eq("bp_tready2", 64'(s_axis_tready), 64'(1));
        check_eq("bp_idx2", 64'(chunk_idx), 64'(1));

        // Final pixel and handshake in the same cycle
        for (int k = 0; k < CP-1; k++) send_pix(24'h200000 + PW'(k), 1'b0, 1'b0);
        send_pix(24'h2000FF, 1'b0, 1'b1);
        check_eq("sim_valid", 64'(chunk_valid), 64'(1));
        check_eq("sim_cur", 64'(px(current_chunk, 0)), 64'h200000);
        check_eq("sim_last", 64'(px(last_chunk, 0)), 64'h100100);
        check_eq("sim_idx", 64'(chunk_idx), 64'(2));
        idle(1'b1);

        // Mid-chunk tuser
        for (int k = 0; k < 100; k++) send_pix(24'h300000 + PW'(k), 1'b0, 1'b1);
        send_pix(24'h123456, 1'b1, 1'b1);
        check_eq("mid_sof_err", 64'(sof_err), 64'(1));
        for (int k = 0; k < CP-1; k++) send_pix(24'h400000 + PW'(k), 1'b0, 1'b1);
        check_eq("mid_valid", 64'(chunk_valid), 64'(1));
        check_eq("mid_msb", 64'(px(current_chunk, 0)), 64'h123456);
        check_eq("mid_px1", 64'(px(current_chunk, 1)), 64'h400000);
        check_eq("mid_first", 64'(chunk_first), 64'(1));
        check_eq("mid_idx", 64'(chunk_idx), 64'(0));
        check_chunk("mid_last", last_chunk, '0);
        idle(1'b1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom % 4) != 0, PW'($urandom), ($urandom % 300) == 0,
                  ($urandom % 3) != 0, acc);
        end
        repeat (3) idle(1'b1);

        // Reset during STALL
        guard = 0;
        while (q.size() < 2 && guard < 4*CP) begin
            cycle(1'b1, PW'($urandom), 1'b0, 1'b0, acc);
            guard++;
        end
        check_eq("stall_reached", 64'(q.size()), 64'(2));
        check_eq("stall_tready", 64'(s_axis_tready), 64'(0));
        do_reset();
        check_eq("post_rst_tready", 64'(s_axis_tready), 64'(0));
        for (int k = 0; k < CP; k++) send_pix(24'h500000 + PW'(k), k == 0, 1'b1);
        check_eq("post_valid", 64'(chunk_valid), 64'(1));
        check_eq("post_lsb", 64'(current_chunk[PW-1:0]), 64'h5000FF);
        check_eq("post_first", 64'(chunk_first), 64'(1));
        check_eq("post_idx", 64'(chunk_idx), 64'(0));
        idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
